// File: rtl/fractal_sync_mp_rsp_pkg.sv
// Shared types for the multi-port barrier responder: per-port FSM states and the reserved NULL signature.
package fractal_sync_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        WAIT,
        CLR,
        RESP
    } fractal_sync_rsp_state_e;

    localparam int unsigned NULL_SIG = 0;

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// N-request one-hot round-robin arbiter; the pointer moves one past the last winner.
module fractal_sync_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    int               idx;

    // Scan from the highest offset down so the request closest to the pointer wins last.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        idx   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % N;
            if (req_i[idx]) begin
                gnt_o = N'(1) << idx;
                ptr_d = PTR_W'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fractal_sync_mp_rsp.sv
// Multi-port barrier responder: serialises per-port sync requests onto a pairwise CAM and releases both arrivals.
// Optional WAIT timeout with stale-line clear is enabled by FRACTAL_SYNC_MP_RSP_TIMEOUT_EN.
module fractal_sync_mp_rsp
    import fractal_sync_pkg::*;
#(
    parameter int          SIG_WIDTH      = 8,
    parameter int          N_PORTS        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [N_PORTS-1:0]                 req_valid_i,
    output logic [N_PORTS-1:0]                 req_ready_o,
    input  logic [N_PORTS-1:0][SIG_WIDTH-1:0]  req_sig_i,
    output logic [N_PORTS-1:0]                 rsp_valid_o,
    input  logic [N_PORTS-1:0]                 rsp_ready_i,
    output logic [N_PORTS-1:0][SIG_WIDTH-1:0]  rsp_sig_o,
    output logic [N_PORTS-1:0]                 rsp_err_o,
    output logic [N_PORTS-1:0][SIG_WIDTH-1:0]  cam_sig_o,
    output logic [N_PORTS-1:0]                 cam_write_o,
    input  logic [N_PORTS-1:0]                 cam_present_i
);

    localparam logic [SIG_WIDTH-1:0] NULL_V = SIG_WIDTH'(NULL_SIG);

    logic [N_PORTS-1:0]                arb_req, gnt;
    logic [N_PORTS-1:0]                match_vld;
    logic [N_PORTS-1:0][SIG_WIDTH-1:0] match_sig;

    fractal_sync_rr_arb #(.N(N_PORTS)) i_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (arb_req),
        .gnt_o  (gnt)
    );

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        fractal_sync_rsp_state_e state_q, state_d;
        logic [SIG_WIDTH-1:0]    sig_q, sig_d;
        logic                    err_q, err_d;
        logic                    hit;

        // A waiter releases when another port's granted store hits on its signature this cycle.
        always_comb begin
            hit = 1'b0;
            for (int q = 0; q < N_PORTS; q++) begin
                if (q != p && match_vld[q] && match_sig[q] == sig_q) hit = 1'b1;
            end
        end

`ifdef FRACTAL_SYNC_MP_RSP_TIMEOUT_EN
        localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
        logic [CNT_W-1:0] cnt_q;
        logic             timeout;

        assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)              cnt_q <= '0;
            else if (state_q != WAIT) cnt_q <= '0;
            else                      cnt_q <= cnt_q + 1'b1;
        end
`endif

        always_comb begin
            state_d = state_q;
            sig_d   = sig_q;
            err_d   = err_q;
            case (state_q)
                IDLE: if (req_valid_i[p]) begin
                    sig_d   = req_sig_i[p];
                    err_d   = (req_sig_i[p] == NULL_V);
                    state_d = (req_sig_i[p] == NULL_V) ? RESP : PEND;
                end
                PEND: if (gnt[p]) begin
                    err_d   = 1'b0;
                    state_d = cam_present_i[p] ? RESP : WAIT;
                end
`ifdef FRACTAL_SYNC_MP_RSP_TIMEOUT_EN
                WAIT: begin
                    if (hit)          state_d = RESP;
                    else if (timeout) state_d = CLR;
                end
                // The granted clear hits the stale line whether or not the CAM still reports it.
                CLR: begin
                    if (hit) begin
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else if (gnt[p]) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
`else
                WAIT: if (hit) state_d = RESP;
`endif
                RESP: if (rsp_ready_i[p]) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= IDLE;
                sig_q   <= NULL_V;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                sig_q   <= sig_d;
                err_q   <= err_d;
            end
        end

        assign req_ready_o[p] = (state_q == IDLE);
        assign rsp_valid_o[p] = (state_q == RESP);
        assign rsp_sig_o[p]   = (state_q == RESP) ? sig_q : NULL_V;
        assign rsp_err_o[p]   = (state_q == RESP) && err_q;
        assign arb_req[p]     = (state_q == PEND) || (state_q == CLR);
        // Ungranted ports present NULL so they can never hit and clear a line.
        assign cam_sig_o[p]   = gnt[p] ? sig_q : NULL_V;
        assign cam_write_o[p] = gnt[p] && (state_q == PEND);
        assign match_vld[p]   = gnt[p] && (state_q == PEND) && cam_present_i[p];
        assign match_sig[p]   = sig_q;
    end

endmodule

// File: tb/tb_fractal_sync_mp_rsp.sv
// Directed bench for fractal_sync_mp_rsp with a stub pairwise CAM; timeout case runs only with FRACTAL_SYNC_MP_RSP_TIMEOUT_EN.
module tb_fractal_sync_mp_rsp;

    localparam int NP = 4;
    localparam int SW = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NP-1:0]          req_valid = '0;
    logic [NP-1:0]          req_ready;
    logic [NP-1:0][SW-1:0]  req_sig = '0;
    logic [NP-1:0]          rsp_valid;
    logic [NP-1:0]          rsp_ready = '1;
    logic [NP-1:0][SW-1:0]  rsp_sig;
    logic [NP-1:0]          rsp_err;
    logic [NP-1:0][SW-1:0]  cam_sig;
    logic [NP-1:0]          cam_write;
    logic [NP-1:0]          cam_present;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fractal_sync_mp_rsp #(
        .SIG_WIDTH      (SW),
        .N_PORTS        (NP),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_sig_i     (req_sig),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_sig_o     (rsp_sig),
        .rsp_err_o     (rsp_err),
        .cam_sig_o     (cam_sig),
        .cam_write_o   (cam_write),
        .cam_present_i (cam_present)
    );

    // Stub CAM: 8 lines, combinational hit, clear on hit, store on write miss, shares reset.
    logic [7:0]         cam_used, cam_used_d;
    logic [7:0][SW-1:0] cam_line, cam_line_d;
    logic               found;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            cam_present[p] = 1'b0;
            for (int l = 0; l < 8; l++)
                if (cam_used[l] && cam_sig[p] != '0 && cam_line[l] == cam_sig[p]) cam_present[p] = 1'b1;
        end
    end

    always_comb begin
        cam_used_d = cam_used;
        cam_line_d = cam_line;
        found      = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (cam_present[p]) begin
                for (int l = 0; l < 8; l++)
                    if (cam_used_d[l] && cam_line_d[l] == cam_sig[p]) cam_used_d[l] = 1'b0;
            end else if (cam_write[p] && cam_sig[p] != '0) begin
                found = 1'b0;
                for (int l = 0; l < 8; l++)
                    if (!found && !cam_used_d[l]) begin
                        cam_used_d[l] = 1'b1;
                        cam_line_d[l] = cam_sig[p];
                        found         = 1'b1;
                    end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_used <= '0;
            cam_line <= '0;
        end else begin
            cam_used <= cam_used_d;
            cam_line <= cam_line_d;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_sig   = '0;
        rsp_ready = '1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if (req_ready !== 4'hF || rsp_valid !== 4'h0 || rsp_err !== 4'h0 || rsp_sig !== '0 ||
            cam_sig !== '0 || cam_write !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rsig=%h csig=%h wr=%b, need rdy=1111 others 0",
                     req_ready, rsp_valid, rsp_err, rsp_sig, cam_sig, cam_write);
        end
        do_reset();
    endtask

    task automatic test_late_partner();
        logic bad;
        do_reset();
        req_valid[0] = 1'b1; req_sig[0] = 8'h05;
        tick();
        req_valid = '0;
        n_tests++;
        if (cam_write !== 4'b0001 || cam_sig[0] !== 8'h05) begin
            n_fail++;
            $display("FAIL p0_store: got wr=%b sig=%h, need 0001 05", cam_write, cam_sig[0]);
        end
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (rsp_valid !== 4'h0 || req_ready[0] !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL p0_wait: got vld=%b rdy=%b, need vld 0000 and p0 not ready throughout", rsp_valid, req_ready);
        end
        req_valid[2] = 1'b1; req_sig[2] = 8'h05;
        tick();
        req_valid = '0;
        n_tests++;
        if (cam_write !== 4'b0100 || cam_present[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL p2_hit: got wr=%b present=%b, need 0100 1", cam_write, cam_present[2]);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 4'b0101 || rsp_sig[0] !== 8'h05 || rsp_sig[2] !== 8'h05 || rsp_err !== 4'h0) begin
            n_fail++;
            $display("FAIL pair_release: got vld=%b s0=%h s2=%h err=%b, need 0101 05 05 0000",
                     rsp_valid, rsp_sig[0], rsp_sig[2], rsp_err);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 4'h0 || req_ready !== 4'hF || cam_used !== 8'h00) begin
            n_fail++;
            $display("FAIL pair_idle: got vld=%b rdy=%b cam=%b, need 0000 1111 00000000", rsp_valid, req_ready, cam_used);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        req_valid = 4'b1010; req_sig[1] = 8'h05; req_sig[3] = 8'h05;
        tick();
        req_valid = '0;
        n_tests++;
        if (cam_write !== 4'b0010) begin
            n_fail++;
            $display("FAIL serial_first: got wr=%b, need 0010", cam_write);
        end
        tick();
        n_tests++;
        if (cam_write !== 4'b1000 || cam_present[3] !== 1'b1 || rsp_valid !== 4'h0) begin
            n_fail++;
            $display("FAIL serial_second: got wr=%b hit=%b vld=%b, need 1000 1 0000", cam_write, cam_present[3], rsp_valid);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 4'b1010 || rsp_err !== 4'h0 || rsp_sig[1] !== 8'h05 || rsp_sig[3] !== 8'h05) begin
            n_fail++;
            $display("FAIL serial_release: got vld=%b err=%b s1=%h s3=%h, need 1010 0000 05 05",
                     rsp_valid, rsp_err, rsp_sig[1], rsp_sig[3]);
        end
    endtask

    task automatic test_null_sig();
        do_reset();
        req_valid[2] = 1'b1; req_sig[2] = 8'h00;
        #1;
        n_tests++;
        if (cam_write !== 4'h0) begin
            n_fail++;
            $display("FAIL null_accept_wr: got %b, need 0000", cam_write);
        end
        tick();
        req_valid = '0;
        n_tests++;
        if (rsp_valid !== 4'b0100 || rsp_err !== 4'b0100 || rsp_sig[2] !== 8'h00 || cam_write !== 4'h0) begin
            n_fail++;
            $display("FAIL null_resp: got vld=%b err=%b sig=%h wr=%b, need 0100 0100 00 0000",
                     rsp_valid, rsp_err, rsp_sig[2], cam_write);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 4'h0 || cam_write !== 4'h0 || req_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL null_done: got vld=%b wr=%b rdy=%b, need 0000 0000 1111", rsp_valid, cam_write, req_ready);
        end
    endtask

    task automatic test_backpressure();
        logic bad;
        do_reset();
        rsp_ready = 4'b1110;
        req_valid = 4'b0011; req_sig[0] = 8'h11; req_sig[1] = 8'h11;
        tick();
        req_valid = '0;
        tick();
        tick();
        n_tests++;
        if (rsp_valid !== 4'b0011) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b, need 0011", rsp_valid);
        end
        tick();
        n_tests++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_p1_idle: got rdy=%b vld=%b, need 1 0", req_ready[1], rsp_valid[1]);
        end
        bad = 1'b0;
        repeat (9) begin
            if (rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 || rsp_sig[0] !== 8'h11) bad = 1'b1;
            tick();
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold: got vld0=%b rdy0=%b sig0=%h, need 1 0 11 throughout", rsp_valid[0], req_ready[0], rsp_sig[0]);
        end
        rsp_ready = '1;
        tick();
        n_tests++;
        if (rsp_valid !== 4'h0 || req_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL bp_drain: got vld=%b rdy=%b, need 0000 1111", rsp_valid, req_ready);
        end
    endtask

`ifdef FRACTAL_SYNC_MP_RSP_TIMEOUT_EN
    task automatic test_timeout();
        logic bad;
        do_reset();
        req_valid[0] = 1'b1; req_sig[0] = 8'h09;
        tick();
        req_valid = '0;
        bad = 1'b0;
        repeat (16) begin
            tick();
            if (rsp_valid !== 4'h0 || cam_write !== 4'h0 || cam_sig[0] !== 8'h00) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL to_wait: got vld=%b wr=%b, need quiet for 16 wait cycles", rsp_valid, cam_write);
        end
        tick();
        n_tests++;
        if (cam_sig[0] !== 8'h09 || cam_write !== 4'h0 || cam_present[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL to_clear: got sig=%h wr=%b hit=%b, need 09 0000 1", cam_sig[0], cam_write, cam_present[0]);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_err !== 4'b0001 || rsp_sig[0] !== 8'h09) begin
            n_fail++;
            $display("FAIL to_resp: got vld=%b err=%b sig=%h, need 0001 0001 09", rsp_valid, rsp_err, rsp_sig[0]);
        end
        tick();
        req_valid[1] = 1'b1; req_sig[1] = 8'h09;
        tick();
        req_valid = '0;
        n_tests++;
        if (cam_write !== 4'b0010 || cam_present[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL to_fresh: got wr=%b hit=%b, need 0010 0", cam_write, cam_present[1]);
        end
        repeat (3) tick();
        n_tests++;
        if (rsp_valid !== 4'h0 || req_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL to_fresh_wait: got vld=%b rdy1=%b, need 0000 0", rsp_valid, req_ready[1]);
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 4'b1101;
        req_valid = 4'b0011; req_sig[0] = 8'h05; req_sig[1] = 8'h00;
        tick();
        req_valid = '0;
        tick();
        tick();
        n_tests++;
        if (rsp_valid !== 4'b0010 || req_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_setup: got vld=%b rdy0=%b, need 0010 0", rsp_valid, req_ready[0]);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 4'hF || rsp_valid !== 4'h0 || rsp_err !== 4'h0 || rsp_sig !== '0 ||
            cam_sig !== '0 || cam_write !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b vld=%b err=%b wr=%b, need 1111 0000 0000 0000",
                     req_ready, rsp_valid, rsp_err, cam_write);
        end
        tick();
        rst_n     = 1'b1;
        rsp_ready = '1;
        req_valid = 4'b0011; req_sig[0] = 8'h05; req_sig[1] = 8'h05;
        tick();
        req_valid = '0;
        n_tests++;
        if (cam_write !== 4'b0001 || cam_present[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_fresh_store: got wr=%b hit=%b, need 0001 0", cam_write, cam_present[0]);
        end
        tick();
        tick();
        n_tests++;
        if (rsp_valid !== 4'b0011 || rsp_err !== 4'h0 || rsp_sig[0] !== 8'h05 || rsp_sig[1] !== 8'h05) begin
            n_fail++;
            $display("FAIL mid_fresh_pair: got vld=%b err=%b s0=%h s1=%h, need 0011 0000 05 05",
                     rsp_valid, rsp_err, rsp_sig[0], rsp_sig[1]);
        end
    endtask

    initial begin
        test_reset();
        test_late_partner();
        test_same_cycle();
        test_null_sig();
        test_backpressure();
`ifdef FRACTAL_SYNC_MP_RSP_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
